// File: rtl/hamming_uart_tx_if.sv
// Codeword handshake between the Hamming(7,4) encoder (master) and the UART
// serializer (slave).
interface hamming_uart_tx_if;
  logic [6:0] code_in;
  logic       valid_in;
  logic       ready_out;

  modport master (output code_in, output valid_in, input ready_out);
  modport slave  (input code_in, input valid_in, output ready_out);
endinterface

// File: rtl/hamming_uart_tx.sv
// UART serializer for Hamming(7,4) codewords: start bit, 7 code bits LSB first,
// STOP_BITS stop bits; a one-word holding register allows gapless back-to-back frames.
module hamming_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  hamming_uart_tx_if.slave up,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [2:0]        BIT_LAST  = 3'd6;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              stop_q, stop_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              hold_full_q, hold_full_d;
  logic [6:0]        hold_q, hold_d;
  logic [6:0]        shift_q, shift_d;

  logic accept;
  logic bit_end;
  logic load;

  assign up.ready_out = ena & ~hold_full_q;
  assign accept       = up.valid_in & up.ready_out;
  assign bit_end      = (baud_q == BAUD_LAST);

  // NOTE: every *_d takes its hold value before the case, so no branch can leave a latch behind.
  always_comb begin
    state_d      = state_q;
    baud_d       = bit_end ? '0 : baud_q + BAUD_W'(1);
    bit_d        = bit_q;
    stop_d       = stop_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    hold_full_d  = hold_full_q;
    hold_d       = hold_q;
    shift_d      = shift_q;
    load         = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            frame_done_d = 1'b1;
            stop_d       = 1'b0;
            // A buffered word starts its start bit straight out of the stop bit.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = up.code_in;
      hold_full_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= 3'd0;
      stop_q       <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      hold_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      hold_full_q  <= hold_full_d;
    end
  end

  // NOTE: hold_q and shift_q are only read when hold_full_q or the FSM qualifies them, so they carry no reset.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // ready_out is low while the holding register is full, so a load and an accept never share an edge.
  assert property (@(posedge clk) disable iff (!rst_n) !(load && accept));
  assert property (@(posedge clk) disable iff (!rst_n) frame_done |=> !frame_done);

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Self-checking bench for hamming_uart_tx: three parameterisations, table-driven
// frames, hand-written corner sequences and a randomized run checked by a UART receiver model.
module tb_hamming_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       valid;
  logic [6:0] code;
  int         sel;

  logic tx_a, busy_a, fd_a;
  logic tx_b, busy_b, fd_b;
  logic tx_c, busy_c, fd_c;
  logic tx_s, busy_s, fd_s, ready_s;

  hamming_uart_tx_if if_a ();
  hamming_uart_tx_if if_b ();
  hamming_uart_tx_if if_c ();

  assign if_a.code_in  = code;
  assign if_b.code_in  = code;
  assign if_c.code_in  = code;
  assign if_a.valid_in = valid & (sel == 0);
  assign if_b.valid_in = valid & (sel == 1);
  assign if_c.valid_in = valid & (sel == 2);

  hamming_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .up(if_a),
    .tx(tx_a), .busy(busy_a), .frame_done(fd_a));
  hamming_uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .up(if_b),
    .tx(tx_b), .busy(busy_b), .frame_done(fd_b));
  hamming_uart_tx #(.CLKS_PER_BIT(2), .STOP_BITS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .up(if_c),
    .tx(tx_c), .busy(busy_c), .frame_done(fd_c));

  assign tx_s    = (sel == 0) ? tx_a   : (sel == 1) ? tx_b   : tx_c;
  assign busy_s  = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign fd_s    = (sel == 0) ? fd_a   : (sel == 1) ? fd_b   : fd_c;
  assign ready_s = (sel == 0) ? if_a.ready_out : (sel == 1) ? if_b.ready_out : if_c.ready_out;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  bit         exp_line[$];
  bit         rec_tx[$];
  bit         rec_busy[$];
  bit         rec_fd[$];
  logic [6:0] sent_q[$];
  logic [6:0] rx_q[$];
  int         fd_cnt, bad_stop, bad_start;

  typedef struct {
    logic [6:0] code;
    logic [8:0] line;  // bit i = line level during bit slot i (slot 0 = start, slot 8 = stop)
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected line level per clock for one frame, straight from the framing rules.
  task automatic model_frame(input logic [6:0] w, input int c, input int s);
    for (int k = 0; k < c; k++) exp_line.push_back(1'b0);
    for (int b = 0; b < 7; b++)
      for (int k = 0; k < c; k++) exp_line.push_back(w[b]);
    for (int k = 0; k < s * c; k++) exp_line.push_back(1'b1);
  endtask

  // Offer one word at a negedge and return at the negedge after the accepting edge.
  task automatic send_word(input logic [6:0] w, input bit keep_valid);
    int t = 0;
    #1;
    code  = w;
    valid = 1'b1;
    while (!ready_s && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("send_ready_seen", ready_s, 1'b1);
    @(negedge clk);
    if (!keep_valid) valid = 1'b0;
  endtask

  // Wait for tx to fall, then record n clocks of tx/busy/frame_done starting there.
  task automatic record(input int n);
    int t = 0;
    rec_tx.delete();
    rec_busy.delete();
    rec_fd.delete();
    do begin
      @(negedge clk);
      t++;
    end while (tx_s !== 1'b0 && t < 400);
    check("tx_fall_seen", tx_s, 1'b0);
    if (tx_s !== 1'b0) return;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      rec_tx.push_back(tx_s);
      rec_busy.push_back(busy_s);
      rec_fd.push_back(fd_s);
    end
  endtask

  task automatic analyze(input string tag, input int len, input int nfr);
    int total    = len * nfr;
    int first_bad = -1;
    int run      = 0;
    int fd_bad   = 0;
    for (int i = 0; i < total; i++)
      if (first_bad < 0 && (i >= rec_tx.size() || i >= exp_line.size() || rec_tx[i] != exp_line[i]))
        first_bad = i;
    check({tag, "_wave_first_bad_cycle"}, first_bad, -1);
    while (run < rec_busy.size() && rec_busy[run]) run++;
    check({tag, "_busy_cycles"}, run, total);
    for (int i = 0; i < total + 2; i++) begin
      bit want = (i > 0) && (i % len == 0) && (i <= total);
      if (i >= rec_fd.size() || rec_fd[i] != want) fd_bad++;
    end
    check({tag, "_frame_done_bad_cycles"}, fd_bad, 0);
  endtask

  // Behavioural UART receiver: detects the start edge and samples mid-bit.
  task automatic rx_model(input int n, input int c);
    int off = -1;
    int cyc = 0;
    logic [6:0] sh = '0;
    while (rx_q.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (fd_s) fd_cnt++;
      if (off < 0) begin
        if (tx_s == 1'b0) off = 0;
      end else begin
        off++;
      end
      if (off >= 0) begin
        if (off == c / 2 && tx_s != 1'b0) begin
          bad_start++;
          off = -1;
        end else begin
          for (int i = 0; i < 7; i++)
            if (off == (i + 1) * c + c / 2) sh[i] = tx_s;
          if (off == 8 * c + c / 2) begin
            if (tx_s != 1'b1) bad_stop++;
            rx_q.push_back(sh);
            off = -1;
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{7'b1010011, 9'b110100110};
    vecs[1] = '{7'h00,      9'b100000000};
    vecs[2] = '{7'h7F,      9'b111111110};
    vecs[3] = '{7'h55,      9'b110101010};
    vecs[4] = '{7'h2A,      9'b101010100};

    rst_n = 1'b1;
    ena   = 1'b1;
    valid = 1'b0;
    code  = '0;
    sel   = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_a", tx_a, 1'b1);
    check("reset_tx_b", tx_b, 1'b1);
    check("reset_tx_c", tx_c, 1'b1);
    check("reset_busy", busy_s, 1'b0);
    check("reset_frame_done", fd_s, 1'b0);
    check("reset_ready", ready_s, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames, CLKS_PER_BIT=4, one stop bit.
    for (int v = 0; v < 5; v++) begin
      exp_line.delete();
      for (int slot = 0; slot < 9; slot++)
        for (int k = 0; k < 4; k++) exp_line.push_back(vecs[v].line[slot]);
      fork
        record(38);
        send_word(vecs[v].code, 1'b0);
      join
      analyze($sformatf("tbl%0d", v), 36, 1);
    end

    // Two words with valid held high: second accepted during START, no idle gap.
    exp_line.delete();
    model_frame(7'h5A, 4, 1);
    model_frame(7'h0F, 4, 1);
    fork
      record(74);
      begin
        send_word(7'h5A, 1'b1);
        send_word(7'h0F, 1'b0);
        check("b2b_accept_in_start_busy_tx", {busy_s, tx_s}, 2'b10);
      end
    join
    analyze("b2b", 36, 2);

    // Two stop bits, CLKS_PER_BIT=3.
    sel = 1;
    exp_line.delete();
    model_frame(7'h7F, 3, 2);
    fork
      record(32);
      send_word(7'h7F, 1'b0);
    join
    analyze("stop2", 30, 1);

    // ena gating, resume, and ena drop mid-frame.
    sel   = 0;
    ena   = 1'b0;
    code  = 7'h35;
    valid = 1'b1;
    @(negedge clk);
    check("ena_low_ready", ready_s, 1'b0);
    begin
      int idle_bad = 0;
      repeat (8) begin
        @(negedge clk);
        if (tx_s !== 1'b1 || busy_s !== 1'b0) idle_bad++;
      end
      check("ena_low_no_tx_cycles", idle_bad, 0);
    end
    exp_line.delete();
    model_frame(7'h35, 4, 1);
    fork
      record(38);
      begin
        ena = 1'b1;
        #1;
        check("ena_rise_ready", ready_s, 1'b1);
        @(negedge clk);
        valid = 1'b0;
        check("ena_accept_tx_still_high", tx_s, 1'b1);
        check("ena_accept_ready_low", ready_s, 1'b0);
        @(negedge clk);
        check("ena_tx_fall_next_edge", tx_s, 1'b0);
        repeat (10) @(negedge clk);
        ena = 1'b0;
      end
    join
    analyze("ena", 36, 1);
    ena = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-DATA with a word buffered.
    send_word(7'h4B, 1'b1);
    send_word(7'h12, 1'b0);
    repeat (8) @(negedge clk);
    check("rst_mid_pre_busy_ready", {busy_s, ready_s}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx_s, 1'b1);
    check("rst_mid_busy", busy_s, 1'b0);
    check("rst_mid_frame_done", fd_s, 1'b0);
    check("rst_mid_ready_eq_ena", ready_s, ena);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int resid = 0;
      repeat (80) begin
        @(negedge clk);
        if (tx_s !== 1'b1 || busy_s !== 1'b0 || fd_s !== 1'b0) resid++;
      end
      check("rst_no_residual_cycles", resid, 0);
    end

    // Random words with random gaps at the minimum bit time.
    sel = 2;
    sent_q.delete();
    rx_q.delete();
    fd_cnt    = 0;
    bad_stop  = 0;
    bad_start = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int gap = $urandom_range(0, 6);
          logic [6:0] w = 7'($urandom_range(0, 127));
          valid = 1'b0;
          repeat (gap) begin
            @(negedge clk);
            code = 7'($urandom);
          end
          sent_q.push_back(w);
          send_word(w, 1'b0);
        end
      end
      rx_model(20, 2);
    join
    repeat (3) begin
      @(negedge clk);
      if (fd_s) fd_cnt++;
    end
    check("rand_rx_count", rx_q.size(), 20);
    for (int i = 0; i < 20; i++)
      if (i < rx_q.size()) check($sformatf("rand_word%0d", i), rx_q[i], sent_q[i]);
    check("rand_bad_stop", bad_stop, 0);
    check("rand_bad_start", bad_start, 0);
    check("rand_frame_done_count", fd_cnt, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
